// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues one imem word read at a time and
// hands each fetched instruction to decode over a valid/ready handshake.
//   clk, reset (async, active-high)
//   redirect_valid/redirect_pc : one-cycle steer to a new fetch address
//   imem_req_valid/ready/addr  : request port (at most one outstanding)
//   imem_rsp_valid/data        : read response, one cycle wide
//   inst_valid/ready/data/pc   : instruction handed to decode
//   misalign_err               : sticky misaligned-redirect flag
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects
// into HALT; without it the low two redirect bits are forced to zero.
module instr_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int INSTR_W = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [WIDTH-1:0]   inst_pc,
  output logic               misalign_err
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pc, pend_pc, tgt;
  logic drop, hs, rsp, redir, bad, keep_drop;
  assign hs = state == REQ && imem_req_ready;
  assign rsp = state == WAIT && imem_rsp_valid;
  assign redir = redirect_valid && state != HALT;
  // A redirect leaves a response in flight either when it collides with the
  // request handshake or when it lands in WAIT before the response arrives.
  assign keep_drop = hs || (state == WAIT && !imem_rsp_valid);
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt = redirect_pc;
  assign bad = redir && |redirect_pc[1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) misalign_err <= 1'b0;
    else if (bad) misalign_err <= 1'b1;
`else
  assign tgt = redirect_pc & ~WIDTH'(3);
  assign bad = 1'b0;
  assign misalign_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= BOOT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      BOOT: state_n = REQ;
      REQ: state_n = hs ? WAIT : REQ;
      WAIT: state_n = rsp ? (drop ? REQ : HOLD) : WAIT;
      HOLD: state_n = inst_ready ? REQ : HOLD;
      default: state_n = state;
    endcase
    if (redir) state_n = bad ? HALT : keep_drop ? WAIT : REQ;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      pend_pc <= '0;
      drop <= 1'b0;
      inst_valid <= 1'b0;
      inst_data <= '0;
      inst_pc <= '0;
    end else begin
      pc <= redir ? tgt : hs ? pc + WIDTH'(4) : pc;
      if (hs) pend_pc <= pc;
      drop <= redir ? keep_drop && !bad : rsp ? 1'b0 : drop;
      inst_valid <= redir ? 1'b0 : (rsp && !drop) ? 1'b1 : (state == HOLD && inst_ready) ? 1'b0 : inst_valid;
      if (!redir && rsp && !drop) begin
        inst_data <= imem_rsp_data;
        inst_pc <= pend_pc;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0;
  logic clk, reset, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic inst_valid, inst_ready, misalign_err;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, inst_data, inst_pc;
  instr_fetch_unit #(.WIDTH(32), .INSTR_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .misalign_err(misalign_err));
  initial clk = 0;
  always #5 clk = ~clk;
  int checks = 0, errs = 0, n_cons = 0, lat_fix = 1;
  bit rnd = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  // imem model: one-word memory with configurable latency
  initial begin
    bit pending;
    int cnt;
    logic [31:0] paddr;
    pending = 0; cnt = 0; paddr = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 0;
      if (pending) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1;
          imem_rsp_data = mem(paddr);
          pending = 0;
        end else cnt--;
      end
      imem_req_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (reset) begin
        pending = 0;
        req_log.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        check("one_outstanding", !pending, {31'b0, pending}, 32'h0);
        check("req_aligned", imem_req_addr[1:0] == 2'b00, imem_req_addr, imem_req_addr & ~32'h3);
        pending = 1;
        cnt = rnd ? int'($urandom_range(1, 4)) : lat_fix;
        paddr = imem_req_addr;
        req_log.push_back(paddr);
      end
    end
  end
  // monitor: pops the expected instruction address on every decode handshake
  initial begin
    bit carry;
    logic [31:0] ppc, pd, e;
    carry = 0; ppc = 0; pd = 0; e = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        check("rst_inst_valid", !inst_valid, {31'b0, inst_valid}, 32'h0);
        check("rst_req_valid", !imem_req_valid, {31'b0, imem_req_valid}, 32'h0);
        check("rst_misalign", !misalign_err, {31'b0, misalign_err}, 32'h0);
        check("rst_inst_pc", inst_pc == 0, inst_pc, 32'h0);
        check("rst_inst_data", inst_data == 0, inst_data, 32'h0);
        carry = 0;
      end else begin
        if (carry) begin
          check("hold_valid", inst_valid, {31'b0, inst_valid}, 32'h1);
          check("hold_pc", inst_pc == ppc, inst_pc, ppc);
          check("hold_data", inst_data == pd, inst_data, pd);
        end
        if (inst_valid) check("no_req_in_hold", !imem_req_valid, {31'b0, imem_req_valid}, 32'h0);
`ifndef FETCH_MISALIGN_CHECK_EN
        check("misalign_tied0", !misalign_err, {31'b0, misalign_err}, 32'h0);
`endif
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (exp_q.size() == 0) check("scoreboard_empty", 1'b0, inst_pc, 32'h0);
          else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc == e, inst_pc, e);
            check("inst_data", inst_data == mem(e), inst_data, mem(e));
            exp_q.push_back(e + 32'h4);
            n_cons++;
          end
        end
        carry = inst_valid && !inst_ready && !redirect_valid;
        ppc = inst_pc;
        pd = inst_data;
      end
    end
  end
  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1;
    redirect_pc = a;
    exp_q.delete();
    exp_q.push_back(a & ~32'h3);
    @(negedge clk);
    redirect_valid = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    exp_q.delete();
    exp_q.push_back(RPC);
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("boot_no_req", !imem_req_valid, {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
  endtask
  task automatic wait_cons(input int n, input int budget);
    int t;
    t = n_cons + n;
    for (int i = 0; i < budget && n_cons < t; i++) @(negedge clk);
    check("progress", n_cons >= t, n_cons, t);
  endtask
  task automatic wait_sig(input bit want_hold, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      hit = want_hold ? inst_valid : imem_req_valid;
      if (!hit) @(negedge clk);
    end
    check(want_hold ? "wait_hold" : "wait_req", hit, {31'b0, hit}, 32'h1);
  endtask
  initial begin
    int idx, n0;
    logic [31:0] a;
    reset = 1; redirect_valid = 0; redirect_pc = 0; inst_ready = 1;
    @(negedge clk);
    do_reset();
    wait_cons(3, 50);
    check("req_log_size", req_log.size() >= 3, req_log.size(), 32'd3);
    if (req_log.size() >= 3)
      for (int i = 0; i < 3; i++) check("first_addrs", req_log[i] == RPC + 32'(4 * i), req_log[i], RPC + 32'(4 * i));
    inst_ready = 0;
    wait_sig(1, 30);
    repeat (5) @(negedge clk);
    inst_ready = 1;
    wait_cons(1, 20);
    lat_fix = 3;
    wait_sig(0, 30);
    @(negedge clk);
    idx = req_log.size();
    redirect(32'h100);
    wait_cons(1, 40);
    check("redir_wait_req", req_log.size() > idx && req_log[idx] == 32'h100, req_log.size() > idx ? req_log[idx] : 32'hx, 32'h100);
    lat_fix = 1;
    inst_ready = 0;
    wait_sig(1, 30);
    inst_ready = 1;
    n0 = n_cons;
    redirect(32'h40);
    check("redir_hold_not_consumed", n_cons == n0, n_cons, n0);
    wait_cons(2, 30);
    wait_sig(0, 30);
    idx = req_log.size();
    redirect(32'h200);
    wait_cons(1, 30);
    check("redir_hs_req", req_log.size() > idx + 1 && req_log[idx + 1] == 32'h200, req_log.size() > idx + 1 ? req_log[idx + 1] : 32'hx, 32'h200);
    redirect(32'hFFFF_FFF8);
    wait_cons(3, 40);
`ifndef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    wait_cons(2, 30);
`endif
    rnd = 1;
    for (int c = 0; c < 4000; c++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      if (c == 2000) do_reset();
      else if ($urandom_range(0, 24) == 0) begin
        a = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
        a = a & ~32'h3;
`endif
        redirect(a);
      end else @(negedge clk);
    end
    rnd = 0;
    inst_ready = 1;
    wait_cons(2, 100);
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt_misalign", misalign_err, {31'b0, misalign_err}, 32'h1);
      check("halt_no_req", !imem_req_valid, {31'b0, imem_req_valid}, 32'h0);
      check("halt_no_inst", !inst_valid, {31'b0, inst_valid}, 32'h0);
      @(negedge clk);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
